// File: rtl/dp_sched_pkg.sv
// Shared types and helpers for the dot product job scheduler.
package dp_sched_pkg;

  localparam int NO_OF_UNITS = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_CLR, S_ISSUE, S_WAIT, S_DONE
  } state_t;

  // Number of engine chunks needed to cover len elements (rounded up).
  function automatic logic [31:0] chunk_count(input logic [31:0] len, input int units);
    return (len + 32'(units) - 32'd1) / 32'(units);
  endfunction

endpackage

// File: rtl/dp_sched_rr_arbiter.sv
// Two-way round-robin arbiter: combinational grant, pointer advances past the winner.
module dp_sched_rr_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       gnt_any,
  output logic       gnt_idx
);

  logic ptr;

  assign gnt_any = |req;
  assign gnt_idx = req[ptr] ? ptr : ~ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       ptr <= 1'b0;
    else if (advance) ptr <= ~gnt_idx;
  end

endmodule

// File: rtl/dot_product_job_scheduler.sv
// Shares one dot product engine between two requesters: arbitrate, clear, stream chunks, return result.
// Define DP_SCHED_TIMEOUT_EN to add a WAIT-state watchdog and the rsp_err output.
module dot_product_job_scheduler
  import dp_sched_pkg::*;
#(
  parameter int NO_OF_UNITS   = dp_sched_pkg::NO_OF_UNITS,
  parameter int ELEMENT_WIDTH = 32,
  parameter int ADDR_W        = 16,
  parameter int LEN_W         = 16,
  parameter int ISSUE_GAP     = 2,
  parameter int RD_LAT        = 1
`ifdef DP_SCHED_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 1024
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               req_valid,
  input  logic [LEN_W-1:0]         req_len_0,
  input  logic [LEN_W-1:0]         req_len_1,
  input  logic [ADDR_W-1:0]        req_base_0,
  input  logic [ADDR_W-1:0]        req_base_1,
  output logic [1:0]               req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_id,
  output logic [ELEMENT_WIDTH-1:0] rsp_data,
`ifdef DP_SCHED_TIMEOUT_EN
  output logic                     rsp_err,
`endif
  output logic                     chunk_rd_en,
  output logic [ADDR_W-1:0]        chunk_rd_addr,
  output logic                     dp_reset,
  output logic [31:0]              dp_total,
  output logic                     dp_read_now,
  input  logic                     dp_finish,
  input  logic [ELEMENT_WIDTH-1:0] dp_result
);

  localparam int GAP_W = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;

  state_t            state, state_nxt;
  logic              gnt_any, gnt_idx, grant;
  logic [LEN_W-1:0]  len_sel, n_sel, n_q, k_q;
  logic [GAP_W-1:0]  gap_q;
  logic [ADDR_W-1:0] addr_q;
  logic [RD_LAT-1:0] vld_pipe;
  logic              issue, timeout, err_pulse;

  assign grant   = (state == S_ARB) && gnt_any;
  assign len_sel = gnt_idx ? req_len_1 : req_len_0;
  assign n_sel   = LEN_W'(chunk_count(32'(len_sel), NO_OF_UNITS));
  assign issue   = (state == S_ISSUE) && (gap_q == '0);

  dp_sched_rr_arbiter u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .advance (grant),
    .gnt_any (gnt_any),
    .gnt_idx (gnt_idx)
  );

`ifdef DP_SCHED_TIMEOUT_EN
  localparam int WAIT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [WAIT_W-1:0] wait_cnt;

  assign timeout = (state == S_WAIT) && !dp_finish && (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt  <= '0;
      err_pulse <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      wait_cnt  <= (state == S_WAIT) ? wait_cnt + WAIT_W'(1) : '0;
      err_pulse <= timeout;
      if (grant)        rsp_err <= 1'b0;
      else if (timeout) rsp_err <= 1'b1;
    end
  end
`else
  assign timeout   = 1'b0;
  assign err_pulse = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (|req_valid) state_nxt = S_ARB;
      S_ARB:   if (!gnt_any) state_nxt = S_IDLE;
               else if (n_sel == '0) state_nxt = S_DONE;
               else state_nxt = S_CLR;
      S_CLR:   state_nxt = S_ISSUE;
      S_ISSUE: if (issue && (k_q == n_q - LEN_W'(1))) state_nxt = S_WAIT;
      S_WAIT:  if (dp_finish || timeout) state_nxt = S_DONE;
      S_DONE:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Engine stays in reset whenever it is not streaming or computing; a zero-length
  // job never releases it, and a timeout re-asserts it on the first DONE cycle.
  always_comb begin
    req_ready = '0;
    if (grant) req_ready[gnt_idx] = 1'b1;
    rsp_valid     = (state == S_DONE);
    chunk_rd_en   = issue;
    chunk_rd_addr = addr_q;
    dp_read_now   = vld_pipe[RD_LAT-1];
    case (state)
      S_ISSUE, S_WAIT: dp_reset = 1'b0;
      S_DONE:          dp_reset = (n_q == '0) || err_pulse;
      default:         dp_reset = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_q      <= '0;
      k_q      <= '0;
      gap_q    <= '0;
      addr_q   <= '0;
      vld_pipe <= '0;
      rsp_id   <= 1'b0;
      rsp_data <= '0;
      dp_total <= '0;
    end else begin
      vld_pipe <= (vld_pipe << 1) | RD_LAT'(issue);
      case (state)
        S_ARB: if (gnt_any) begin
          n_q      <= n_sel;
          k_q      <= '0;
          gap_q    <= '0;
          addr_q   <= gnt_idx ? req_base_1 : req_base_0;
          rsp_id   <= gnt_idx;
          rsp_data <= '0;
          dp_total <= 32'(n_sel) * 32'(NO_OF_UNITS);
        end
        S_ISSUE: begin
          gap_q <= (gap_q == GAP_W'(ISSUE_GAP - 1)) ? '0 : gap_q + GAP_W'(1);
          if (issue) begin
            addr_q <= addr_q + ADDR_W'(1);
            k_q    <= k_q + LEN_W'(1);
          end
        end
        S_WAIT: if (dp_finish) rsp_data <= dp_result;
        default: ;
      endcase
    end
  end

endmodule
